// File: rtl/count_sequencer.sv
// Sequencer that turns a parallel-load binary counter into a programmable period generator.
// Load/Count/tick are combinational from state, A_count and pause; no flow-control backpressure.
module count_sequencer #(
  parameter int WIDTH  = 4,
  parameter int PWIDTH = 8
) (
  input  logic              CLK,
  input  logic              Clear,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic [WIDTH-1:0]  preset,
  input  logic [PWIDTH-1:0] periods,
  input  logic [WIDTH-1:0]  A_count,
  output logic              Load,
  output logic              Count,
  output logic [WIDTH-1:0]  Data_in,
  output logic              busy,
  output logic              tick,
  output logic              done,
  output logic [PWIDTH-1:0] period_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   preset_q, preset_d;
  logic [PWIDTH-1:0]  target_q, target_d;
  logic [PWIDTH-1:0]  period_cnt_q, period_cnt_d;
  logic [PWIDTH-1:0]  cnt_inc;
  logic               at_top;
  logic               term;

  assign at_top  = (A_count == {WIDTH{1'b1}});
  // Abort suppresses the terminal reload so the aborted period leaves no trace.
  assign term    = (state_q == S_RUN) & at_top & ~pause & ~abort;
  assign cnt_inc = period_cnt_q + PWIDTH'(1);

  always_comb begin
    state_d      = state_q;
    preset_d     = preset_q;
    target_d     = target_q;
    period_cnt_d = period_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && (periods != '0)) begin
          preset_d     = preset;
          target_d     = periods;
          period_cnt_d = '0;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (term) begin
          period_cnt_d = cnt_inc;
          if (cnt_inc == target_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Clear) begin
      state_q      <= S_IDLE;
      preset_q     <= '0;
      target_q     <= '0;
      period_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      preset_q     <= preset_d;
      target_q     <= target_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  assign Load       = ((state_q == S_LOAD) & ~abort) | term;
  assign Count      = (state_q == S_RUN) & ~pause;
  assign busy       = (state_q == S_LOAD) | (state_q == S_RUN);
  assign tick       = term;
  assign done       = (state_q == S_DONE);
  assign Data_in    = preset_q;
  assign period_cnt = period_cnt_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench: sequencer driving a behavioural 4-bit parallel-load counter.
module tb_count_sequencer;

  logic       CLK = 1'b0;
  logic       Clear, start, abort, pause;
  logic [3:0] preset;
  logic [7:0] periods;
  logic [3:0] A_count = 4'h0;
  logic       Load, Count, busy, tick, done;
  logic [3:0] Data_in;
  logic [7:0] period_cnt;

  int checks   = 0;
  int failures = 0;

  count_sequencer #(.WIDTH(4), .PWIDTH(8)) dut (
    .CLK(CLK), .Clear(Clear), .start(start), .abort(abort), .pause(pause),
    .preset(preset), .periods(periods), .A_count(A_count),
    .Load(Load), .Count(Count), .Data_in(Data_in), .busy(busy),
    .tick(tick), .done(done), .period_cnt(period_cnt)
  );

  always #5 CLK = ~CLK;

  // Downstream counter: load has priority over count.
  always @(posedge CLK) begin
    if (Load)       A_count <= Data_in;
    else if (Count) A_count <= A_count + 4'd1;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] pc);
    chk({tag, "_load"},  32'(Load), 0);
    chk({tag, "_count"}, 32'(Count), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_tick"},  32'(tick), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_pcnt"},  32'(period_cnt), 32'(pc));
  endtask

  // Runs one sequence, predicting the counter value and ticks cycle by cycle.
  // ps/pl: pause window in RUN cycles (pl=0 disables); poke: RUN cycle with a stray start.
  task automatic run_seq(input string tag, input logic [3:0] pre, input logic [7:0] np,
                         input int ps, input int pl, input int poke, input int exp_cycles);
    logic [3:0] a_exp;
    int         cnt;
    int         r;
    logic       pz, t_exp;
    preset  = pre;
    periods = np;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    chk({tag, "_ld_load"}, 32'(Load), 1);
    chk({tag, "_ld_count"}, 32'(Count), 0);
    chk({tag, "_ld_busy"}, 32'(busy), 1);
    chk({tag, "_ld_data"}, 32'(Data_in), 32'(pre));
    chk({tag, "_ld_pcnt"}, 32'(period_cnt), 0);
    cyc();
    a_exp = pre;
    cnt   = 0;
    r     = 0;
    while (cnt < int'(np) && r < 300) begin
      r++;
      pz    = (r >= ps) && (r < ps + pl);
      pause = pz;
      if (r == poke) begin
        start   = 1'b1;
        preset  = ~pre;
        periods = np + 8'd5;
      end
      #1;
      t_exp = !pz && (a_exp == 4'hF);
      chk($sformatf("%s_a_r%0d", tag, r),     32'(A_count), 32'(a_exp));
      chk($sformatf("%s_tick_r%0d", tag, r),  32'(tick), 32'(t_exp));
      chk($sformatf("%s_load_r%0d", tag, r),  32'(Load), 32'(t_exp));
      chk($sformatf("%s_count_r%0d", tag, r), 32'(Count), 32'(!pz));
      chk($sformatf("%s_busy_r%0d", tag, r),  32'(busy), 1);
      chk($sformatf("%s_pcnt_r%0d", tag, r),  32'(period_cnt), 32'(cnt));
      chk($sformatf("%s_data_r%0d", tag, r),  32'(Data_in), 32'(pre));
      if (t_exp) begin
        cnt++;
        a_exp = pre;
      end else if (!pz) begin
        a_exp = a_exp + 4'd1;
      end
      cyc();
      start   = 1'b0;
      pause   = 1'b0;
      preset  = pre;
      periods = np;
    end
    chk({tag, "_run_len"}, 32'(r), 32'(exp_cycles));
    chk({tag, "_dn_done"}, 32'(done), 1);
    chk({tag, "_dn_busy"}, 32'(busy), 0);
    chk({tag, "_dn_load"}, 32'(Load), 0);
    chk({tag, "_dn_count"}, 32'(Count), 0);
    chk({tag, "_dn_pcnt"}, 32'(period_cnt), 32'(np));
    cyc();
    chk_idle({tag, "_post"}, np);
  endtask

  initial begin
    Clear   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    pause   = 1'b0;
    preset  = 4'h0;
    periods = 8'd0;
    cyc();
    cyc();
    Clear = 1'b0;
    chk_idle("reset", 8'd0);
    chk("reset_data", 32'(Data_in), 0);

    // Basic run: period 4, three periods.
    run_seq("c3", 4'hC, 8'd3, 0, 0, 0, 12);
    // preset all-ones: tick every RUN cycle.
    run_seq("f5", 4'hF, 8'd5, 0, 0, 0, 5);
    // preset zero: 16-cycle periods, reload instead of wrap.
    run_seq("z2", 4'h0, 8'd2, 0, 0, 0, 32);
    // Pause at A_count=D (RUN cycle 2) for 3 cycles: done slips by 3.
    run_seq("pz", 4'hC, 8'd3, 2, 3, 0, 15);
    // Stray start during RUN cycle 3 must not disturb the run.
    run_seq("pk", 4'hC, 8'd3, 0, 0, 3, 12);

    // start with periods=0 is ignored.
    preset  = 4'h7;
    periods = 8'd0;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    chk_idle("p0", 8'd3);
    chk("p0_data", 32'(Data_in), 32'hC);
    cyc();
    chk_idle("p0b", 8'd3);

    // Abort at A_count=E in period 2 (RUN cycle 7).
    preset  = 4'hC;
    periods = 8'd3;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    chk("ab_a", 32'(A_count), 32'hE);
    chk("ab_pcnt_pre", 32'(period_cnt), 1);
    abort = 1'b1;
    #1;
    chk("ab_load", 32'(Load), 0);
    chk("ab_tick", 32'(tick), 0);
    cyc();
    abort = 1'b0;
    chk_idle("ab_post", 8'd1);
    cyc();
    chk_idle("ab_post2", 8'd1);

    // Abort landing on a terminal cycle: Load and tick must be suppressed.
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("abt_a", 32'(A_count), 32'hF);
    abort = 1'b1;
    #1;
    chk("abt_load", 32'(Load), 0);
    chk("abt_tick", 32'(tick), 0);
    cyc();
    abort = 1'b0;
    chk_idle("abt_post", 8'd0);

    // Abort in LOAD.
    start = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b1;
    #1;
    chk("abl_load", 32'(Load), 0);
    cyc();
    abort = 1'b0;
    chk_idle("abl_post", 8'd0);

    // Clear mid-run after one completed period (preset 5: period 11).
    preset  = 4'h5;
    periods = 8'd4;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    for (int i = 0; i < 13; i++) cyc();
    chk("clr_busy_pre", 32'(busy), 1);
    chk("clr_pcnt_pre", 32'(period_cnt), 1);
    Clear = 1'b1;
    cyc();
    Clear = 1'b0;
    chk_idle("clr_post", 8'd0);
    chk("clr_data", 32'(Data_in), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
